// File: rtl/slurm32_interrupt_controller.sv
// Prioritised, edge-triggered interrupt controller feeding the slurm32 pipeline's interrupt/irq inputs.
// Optional IRQ_SYNC_EN: adds a 2-flop synchroniser on every irq_lines bit ahead of edge detection.
module slurm32_interrupt_controller #(
  parameter int NUM_IRQ = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               interrupt_taken,
  input  logic [1:0]         ADDRESS,
  input  logic [15:0]        DATA_IN,
  input  logic               WR,
  output logic [15:0]        DATA_OUT,
  output logic               interrupt,
  output logic [3:0]         irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_FORCE   = 2'd3;

  logic [NUM_IRQ-1:0] lines_s;
  logic [NUM_IRQ-1:0] hist_reg;
  logic [1:0]         mask_cnt_reg;
  logic [NUM_IRQ-1:0] enable_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] force_set;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic [NUM_IRQ-1:0] auto_clr;
  logic [NUM_IRQ-1:0] active;
  logic [15:0]        enable_16;
  logic [15:0]        pending_16;
  logic [15:0]        status_16;
  logic [15:0]        read_next;
  logic [1:0]         state_reg;
  logic               interrupt_reg;
  logic [3:0]         irq_reg;
  logic [3:0]         winner;
  logic               any_active;
  logic               take_now;

`ifdef IRQ_SYNC_EN
  // Mask spans the synchroniser depth so lines already high at reset release stay quiet.
  localparam logic [1:0] MASK_CYCLES = 2'd3;

  logic [NUM_IRQ-1:0] sync1_reg;
  logic [NUM_IRQ-1:0] sync2_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_lines;
      sync2_reg <= sync1_reg;
    end
  end

  assign lines_s = sync2_reg;
`else
  localparam logic [1:0] MASK_CYCLES = 2'd1;

  assign lines_s = irq_lines;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_reg     <= '0;
      mask_cnt_reg <= MASK_CYCLES;
    end else begin
      hist_reg <= lines_s;
      if (mask_cnt_reg != 2'd0) begin
        mask_cnt_reg <= mask_cnt_reg - 2'd1;
      end
    end
  end

  assign edge_set  = (mask_cnt_reg == 2'd0) ? (lines_s & ~hist_reg) : '0;
  assign force_set = (WR && ADDRESS == ADDR_FORCE)   ? DATA_IN[NUM_IRQ-1:0] : '0;
  assign w1c_clr   = (WR && ADDRESS == ADDR_PENDING) ? DATA_IN[NUM_IRQ-1:0] : '0;
  assign take_now  = (state_reg == ST_ASSERT) && interrupt_taken;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_auto_clr
    assign auto_clr[gi] = take_now && (irq_reg == 4'(gi));
  end

  // Sets are applied after clears so a coincident new event is never lost.
  assign pending_next = (pending_reg & ~(w1c_clr | auto_clr)) | edge_set | force_set;
  assign active       = pending_reg & enable_reg;
  assign any_active   = |active;

  always_comb begin
    winner = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner = i[3:0];
      end
    end
  end

  always_comb begin
    enable_16                = '0;
    pending_16               = '0;
    enable_16[NUM_IRQ-1:0]   = enable_reg;
    pending_16[NUM_IRQ-1:0]  = pending_reg;
    status_16                = {interrupt_reg, 11'd0, irq_reg};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      enable_reg  <= '0;
      pending_reg <= '0;
    end else begin
      if (WR && ADDRESS == ADDR_ENABLE) begin
        enable_reg <= DATA_IN[NUM_IRQ-1:0];
      end
      pending_reg <= pending_next;
    end
  end

  // The request is frozen once raised; only taken or a withdrawn source ends it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      interrupt_reg <= 1'b0;
      irq_reg       <= 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_active) begin
            irq_reg       <= winner;
            interrupt_reg <= 1'b1;
            state_reg     <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (interrupt_taken) begin
            interrupt_reg <= 1'b0;
            state_reg     <= ST_GAP;
          end else if (!pending_16[irq_reg] || !enable_16[irq_reg]) begin
            interrupt_reg <= 1'b0;
            state_reg     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          interrupt_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    read_next = 16'd0;
    case (ADDRESS)
      ADDR_ENABLE:  read_next = enable_16;
      ADDR_PENDING: read_next = pending_16;
      ADDR_STATUS:  read_next = status_16;
      default:      read_next = 16'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_OUT <= 16'd0;
    end else begin
      DATA_OUT <= read_next;
    end
  end

  assign interrupt = interrupt_reg;
  assign irq       = irq_reg;

endmodule
